full_adder_core: RTL and testbench
==================================

Name: full_adder_core

Overview:
- Parameterizable ripple-carry adder; default WIDTH=1 is the classic 1-bit full adder (a + b + cin -> sum, cout).
- Provides two result paths:
  - a purely combinational path (sum, cout);
  - a 1-cycle registered path (sum_q, cout_q, valid_q) for pipelined datapaths.
- Used as the leaf arithmetic primitive in the arithmetic library.

Parameters:
- WIDTH, 1, operand width in bits (>=1); WIDTH=1 gives the single-bit full adder.

Ports:
- clk  input  1  rising-edge clock for the registered path
- rst  input  1  asynchronous, active-high reset; clears the registered path only
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry in
- in_valid  input  1  qualifies a/b/cin for capture into the registered path
- sum  output  WIDTH  combinational sum = (a + b + cin) mod 2^WIDTH
- cout  output  1  combinational carry out = bit WIDTH of (a + b + cin)
- prop  output  WIDTH  per-bit propagate, a XOR b (combinational)
- gen  output  WIDTH  per-bit generate, a AND b (combinational)
- sum_q  output  WIDTH  registered sum
- cout_q  output  1  registered carry out
- valid_q  output  1  registered in_valid

Behaviour:
- Bit i of the combinational path:
  - sum[i] = a[i] ^ b[i] ^ c[i];
  - c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  - c[0] = cin; cout = c[WIDTH].
- Combinational outputs:
  - No dependence on clk, rst or in_valid.
  - Settle within the same delta/cycle as any input change.
  - Valid while rst is asserted.
- Result width is WIDTH+1 ({cout, sum}). There is no overflow flag: wrap-around is expressed solely via cout.
- Registered path:
  - On rising clk with in_valid=1, capture sum->sum_q and cout->cout_q.
  - valid_q <= in_valid on every rising clk.
  - When in_valid=0, sum_q/cout_q hold their previous values.
  - Latency is 1 clock.
- Reset:
  - rst=1 immediately (asynchronously) forces sum_q=0, cout_q=0, valid_q=0, regardless of clk.
  - Deassertion is sampled at the next rising clk; the first capture can occur on the first rising edge with rst=0.
- Reset asserted mid-operation: any in-flight registered result is discarded; the combinational outputs are unaffected.
- Boundary cases:
  - All-ones operands with cin=1 give sum = all ones and cout=1.
  - All zeros with cin=0 gives sum=0, cout=0.
  - Simultaneous input change at the clock edge: the value present before the edge is captured.
- No X propagation from unused logic.
- Every output must be driven for all input combinations; no latches.

Test Plan:
- Exhaustive, WIDTH=1: step {a,b,cin} 000..111 every 10 time units. Required (sum,cout):
  - 000->(0,0), 001->(1,0), 010->(1,0), 011->(0,1);
  - 100->(1,0), 101->(0,1), 110->(0,1), 111->(1,1).
- Propagate/generate, WIDTH=1: a=1,b=0 -> prop=1, gen=0; a=1,b=1 -> prop=0, gen=1.
- Registered latency, WIDTH=1: a=1, b=1, cin=1, in_valid=1 at an edge -> after that edge sum_q=1, cout_q=1, valid_q=1.
  - Next cycle with in_valid=0 and new inputs: valid_q=0, sum_q/cout_q hold 1/1.
- Async reset: assert rst between clock edges while sum_q=1 -> sum_q, cout_q, valid_q drop to 0 immediately.
  - Combinational sum/cout still track the inputs during reset.
- Wrap-around, WIDTH=4: a=4'hF, b=4'h0, cin=1 -> sum=4'h0, cout=1.
  - Also a=4'h7, b=4'h8, cin=0 -> sum=4'hF, cout=0.
- Random, WIDTH=8: 1000 random {a,b,cin} vectors.
  - Check {cout,sum} == a+b+cin each time.
  - Check {cout_q,sum_q} equals the previous cycle's value whenever the previous cycle had in_valid=1.

Source files
------------

// File: rtl/full_adder_core.sv
// ---------------------------------------------------------------------------
// full_adder_core
//
// Leaf ripple-carry adder for the arithmetic library. With the default
// WIDTH=1 this is the classic single-bit full adder.
//
// Two result paths are provided:
//   * combinational: sum/cout/prop/gen follow a, b and cin directly and do
//     not depend on clk, rst or in_valid.
//   * registered: sum_q/cout_q capture the combinational result one clock
//     after in_valid, and valid_q is in_valid delayed by one clock.
//
// Ports:
//   clk       in   1      rising-edge clock for the registered path
//   rst       in   1      asynchronous active-high reset (registered path only)
//   a, b      in   WIDTH  operands
//   cin       in   1      carry in
//   in_valid  in   1      qualifies a/b/cin for capture
//   sum       out  WIDTH  (a + b + cin) mod 2^WIDTH
//   cout      out  1      bit WIDTH of (a + b + cin)
//   prop      out  WIDTH  per-bit propagate, a ^ b
//   gen       out  WIDTH  per-bit generate, a & b
//   sum_q     out  WIDTH  registered sum
//   cout_q    out  1      registered carry out
//   valid_q   out  1      registered in_valid
//
// Handshake: in_valid is a one-way qualifier with no back-pressure. A result
// is captured on every rising clk where in_valid=1; valid_q marks the cycle
// in which that result is presented on sum_q/cout_q. When in_valid=0 the
// previous result is held.
// ---------------------------------------------------------------------------
module full_adder_core #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] prop,
    output logic [WIDTH-1:0] gen,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             valid_q
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;

    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             valid_d;

    // Explicit ripple chain, bit by bit, so the structure matches the
    // textbook full-adder cell and the carry is visible per bit.
    always_comb begin
        carry    = '0;
        sum_c    = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum_c[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign sum  = sum_c;
    assign cout = carry[WIDTH];
    assign prop = a ^ b;
    assign gen  = a & b;

    // Capture only when qualified; otherwise hold the last result.
    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d  = sum_c;
            cout_d = carry[WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_full_adder_core.sv
// ---------------------------------------------------------------------------
// tb_full_adder_core
//
// Directed bench for full_adder_core at WIDTH=1, 4 and 8 (three instances
// sharing clk/rst). Expected values come from hand-written tables and from
// plain integer addition.
// ---------------------------------------------------------------------------
module tb_full_adder_core;

    // ------------------------------------------------------------------
    // clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic [0:0] a1, b1, sum1, prop1, gen1, sum_q1;
    logic       cin1, iv1, cout1, cout_q1, valid_q1;

    logic [3:0] a4, b4, sum4, prop4, gen4, sum_q4;
    logic       cin4, iv4, cout4, cout_q4, valid_q4;

    logic [7:0] a8, b8, sum8, prop8, gen8, sum_q8;
    logic       cin8, iv8, cout8, cout_q8, valid_q8;

    full_adder_core #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
        .sum(sum1), .cout(cout1), .prop(prop1), .gen(gen1),
        .sum_q(sum_q1), .cout_q(cout_q1), .valid_q(valid_q1)
    );

    full_adder_core #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .in_valid(iv4),
        .sum(sum4), .cout(cout4), .prop(prop4), .gen(gen4),
        .sum_q(sum_q4), .cout_q(cout_q4), .valid_q(valid_q4)
    );

    full_adder_core #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
        .sum(sum8), .cout(cout8), .prop(prop8), .gen(gen8),
        .sum_q(sum_q8), .cout_q(cout_q8), .valid_q(valid_q8)
    );

    // ------------------------------------------------------------------
    // scoreboard
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] exp_q[$];   // {valid_q, cout_q, sum_q} expected after next edge

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // driver tasks
    // ------------------------------------------------------------------
    task automatic drive_w1(input logic av, input logic bv, input logic cv,
                            input logic vv);
        a1 = av; b1 = bv; cin1 = cv; iv1 = vv;
    endtask

    task automatic drive_w4(input logic [3:0] av, input logic [3:0] bv,
                            input logic cv);
        a4 = av; b4 = bv; cin4 = cv;
    endtask

    // Hard bound so the bench can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // stimulus
    // ------------------------------------------------------------------
    logic [7:0] sum_tab;
    logic [7:0] cout_tab;
    logic [2:0] vec;
    logic [8:0] ref9;
    logic [7:0] held_sum8;
    logic       held_cout8;

    initial begin
        rst = 1'b1;
        drive_w1(1'b0, 1'b0, 1'b0, 1'b0);
        drive_w4(4'h0, 4'h0, 1'b0);
        iv4 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; iv8 = 1'b0;

        // Reset state of the registered path.
        #1;
        check_val("rst_sum_q1",   32'(sum_q1),   32'h0);
        check_val("rst_cout_q1",  32'(cout_q1),  32'h0);
        check_val("rst_valid_q1", 32'(valid_q1), 32'h0);
        check_val("rst_sum_q8",   32'(sum_q8),   32'h0);

        // Combinational path is live while rst is held.
        drive_w1(1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        check_val("rst_comb_sum1",  32'(sum1),  32'h0);
        check_val("rst_comb_cout1", 32'(cout1), 32'h1);
        @(posedge clk); #1;
        check_val("rst_hold_valid_q1", 32'(valid_q1), 32'h0);
        drive_w1(1'b0, 1'b0, 1'b0, 1'b0);

        // Exhaustive WIDTH=1 truth table, one vector every 10 time units.
        sum_tab  = 8'b1001_0110;
        cout_tab = 8'b1110_1000;
        for (int v = 0; v < 8; v++) begin
            vec = 3'(v);
            drive_w1(vec[2], vec[1], vec[0], 1'b0);
            #10;
            check_val($sformatf("tt_sum_%0d", v),  32'(sum1),  32'(sum_tab[v]));
            check_val($sformatf("tt_cout_%0d", v), 32'(cout1), 32'(cout_tab[v]));
        end

        // Propagate / generate at WIDTH=1.
        drive_w1(1'b1, 1'b0, 1'b0, 1'b0); #1;
        check_val("pg_prop_10", 32'(prop1), 32'h1);
        check_val("pg_gen_10",  32'(gen1),  32'h0);
        drive_w1(1'b1, 1'b1, 1'b0, 1'b0); #1;
        check_val("pg_prop_11", 32'(prop1), 32'h0);
        check_val("pg_gen_11",  32'(gen1),  32'h1);

        // Release reset away from the edge; first capture on next rise.
        @(negedge clk);
        rst = 1'b0;
        drive_w1(1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check_val("first_sum_q1",   32'(sum_q1),   32'h1);
        check_val("first_cout_q1",  32'(cout_q1),  32'h0);
        check_val("first_valid_q1", 32'(valid_q1), 32'h1);

        // Registered latency: 1+1+1 captured.
        @(negedge clk);
        drive_w1(1'b1, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        check_val("lat_sum_q1",   32'(sum_q1),   32'h1);
        check_val("lat_cout_q1",  32'(cout_q1),  32'h1);
        check_val("lat_valid_q1", 32'(valid_q1), 32'h1);

        // New inputs without in_valid: result holds, valid drops.
        @(negedge clk);
        drive_w1(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_val("hold_valid_q1", 32'(valid_q1), 32'h0);
        check_val("hold_sum_q1",   32'(sum_q1),   32'h1);
        check_val("hold_cout_q1",  32'(cout_q1),  32'h1);

        // Capture a 1/1 result again, then assert rst between edges.
        @(negedge clk);
        drive_w1(1'b1, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #2;
        drive_w1(1'b1, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        check_val("arst_sum_q1",   32'(sum_q1),   32'h0);
        check_val("arst_cout_q1",  32'(cout_q1),  32'h0);
        check_val("arst_valid_q1", 32'(valid_q1), 32'h0);
        check_val("arst_comb_sum1",  32'(sum1),  32'h0);
        check_val("arst_comb_cout1", 32'(cout1), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        drive_w1(1'b0, 1'b0, 1'b0, 1'b0);

        // WIDTH=4 boundary and wrap-around vectors.
        drive_w4(4'hF, 4'h0, 1'b1); #1;
        check_val("w4_wrap_sum",  32'(sum4),  32'h0);
        check_val("w4_wrap_cout", 32'(cout4), 32'h1);
        drive_w4(4'h7, 4'h8, 1'b0); #1;
        check_val("w4_78_sum",  32'(sum4),  32'hF);
        check_val("w4_78_cout", 32'(cout4), 32'h0);
        drive_w4(4'hF, 4'hF, 1'b1); #1;
        check_val("w4_ones_sum",  32'(sum4),  32'hF);
        check_val("w4_ones_cout", 32'(cout4), 32'h1);
        drive_w4(4'h0, 4'h0, 1'b0); #1;
        check_val("w4_zero_sum",  32'(sum4),  32'h0);
        check_val("w4_zero_cout", 32'(cout4), 32'h0);
        drive_w4(4'hC, 4'hA, 1'b0); #1;
        check_val("w4_prop", 32'(prop4), 32'h6);
        check_val("w4_gen",  32'(gen4),  32'h8);
        check_val("w4_ca_sum",  32'(sum4),  32'h6);
        check_val("w4_ca_cout", 32'(cout4), 32'h1);

        // WIDTH=8 random vectors. The registered path has been reset and
        // never captured since, so the held result starts at zero.
        held_sum8  = 8'h00;
        held_cout8 = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a8   = 8'($urandom_range(0, 255));
            b8   = 8'($urandom_range(0, 255));
            cin8 = 1'($urandom_range(0, 1));
            iv8  = 1'($urandom_range(0, 1));
            #1;
            ref9 = 9'(a8) + 9'(b8) + 9'(cin8);
            check_val("w8_comb", 32'({cout8, sum8}), 32'(ref9));
            if (iv8) begin
                held_sum8  = ref9[7:0];
                held_cout8 = ref9[8];
            end
            exp_q.push_back({iv8, held_cout8, held_sum8});
            @(posedge clk); #1;
            check_val("w8_reg", 32'({valid_q8, cout_q8, sum_q8}),
                      32'(exp_q.pop_front()));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
